// File: rtl/rollover_gen.sv
// rollover_gen: programmable tick generator feeding the clock-toggle stage.
//
// Counts enabled i_clk cycles with a down-counter and emits a one-cycle registered
// o_roll_over pulse every m_period enabled cycles. Supports continuous and one-shot
// operation and a valid/ready period-update port with a shadow register.
//
// Optional feature (macro ROLLOVER_GEN_ROLL_CNT_EN): adds o_roll_cnt, a saturating count
// of rollover pulses since the last start.
//
// Ports:
//   i_clk          system clock, posedge
//   i_reset        asynchronous active-low reset
//   i_enable       count qualifier
//   i_start        start request (sampled in IDLE, also holds DONE while high)
//   i_stop         stop request, forces IDLE, highest priority
//   i_oneshot      mode select latched at start (1 = single rollover then DONE)
//   i_period       new period value (0 is clamped to 1)
//   i_period_valid i_period offered
//   o_period_ready period update can be accepted
//   o_roll_over    registered rollover pulse. With period 1 and i_enable held high it
//                  stays high continuously; only level-sensitive consumers tolerate that.
//   o_count        current down-counter value
//   o_busy         high in RUN
//   o_roll_cnt     (ROLLOVER_GEN_ROLL_CNT_EN only) saturating rollover count

module rollover_gen #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned DEFAULT_PERIOD = 10
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_oneshot,
  input  logic [WIDTH-1:0] i_period,
  input  logic             i_period_valid,
  output logic             o_period_ready,
  output logic             o_roll_over,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy
`ifdef ROLLOVER_GEN_ROLL_CNT_EN
  ,
  output logic [WIDTH-1:0] o_roll_cnt
`endif
);

  localparam logic [WIDTH-1:0] DefPeriod = WIDTH'(DEFAULT_PERIOD);
  localparam logic [WIDTH-1:0] One       = WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state;
  logic [WIDTH-1:0] m_period;
  logic [WIDTH-1:0] shadow;
  logic             shadow_full;
  logic [WIDTH-1:0] count;
  logic             roll;
  logic             oneshot;

  logic             xfer;
  logic             roll_set;
  logic [WIDTH-1:0] new_period;
  logic [WIDTH-1:0] reload;

  // Ready only drops while a shadowed value waits for its rollover.
  assign o_period_ready = ~shadow_full;
  assign xfer           = i_period_valid & o_period_ready;
  assign new_period     = (i_period == '0) ? One : i_period;
  // A pending shadow value takes effect on the very reload that consumes it.
  assign reload         = shadow_full ? (shadow - One) : (m_period - One);
  assign roll_set       = ~i_stop && (state == StRun) && i_enable && (count == '0);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= StIdle;
      m_period    <= DefPeriod;
      shadow      <= '0;
      shadow_full <= 1'b0;
      count       <= DefPeriod - One;
      roll        <= 1'b0;
      oneshot     <= 1'b0;
    end else begin
      roll <= 1'b0;
      if (i_stop) begin
        // Stop wins over start and over a coincident rollover; pending shadow is dropped.
        state       <= StIdle;
        shadow_full <= 1'b0;
        if (xfer) begin
          m_period <= new_period;
          count    <= new_period - One;
        end else begin
          count <= m_period - One;
        end
      end else begin
        unique case (state)
          StIdle: begin
            if (xfer) m_period <= new_period;
            if (i_start) begin
              state   <= StRun;
              oneshot <= i_oneshot;
              count   <= m_period - One;
            end else if (xfer) begin
              count <= new_period - One;
            end
          end
          StRun: begin
            // xfer implies the shadow is empty, so it never collides with the clear below.
            if (xfer) begin
              shadow      <= new_period;
              shadow_full <= 1'b1;
            end
            if (i_enable) begin
              if (count != '0) begin
                count <= count - One;
              end else begin
                roll <= 1'b1;
                if (shadow_full) begin
                  m_period    <= shadow;
                  shadow_full <= 1'b0;
                end
                if (oneshot) begin
                  state <= StDone;
                  count <= '0;
                end else begin
                  count <= reload;
                end
              end
            end
          end
          StDone: begin
            if (xfer) m_period <= new_period;
            if (!i_start) begin
              state <= StIdle;
              count <= xfer ? (new_period - One) : (m_period - One);
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

  assign o_roll_over = roll;
  assign o_count     = count;
  assign o_busy      = (state == StRun);

`ifdef ROLLOVER_GEN_ROLL_CNT_EN
  logic [WIDTH-1:0] roll_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      roll_cnt <= '0;
    end else if (!i_stop && (state == StIdle) && i_start) begin
      roll_cnt <= '0;
    end else if (roll_set && (roll_cnt != '1)) begin
      roll_cnt <= roll_cnt + One;
    end
  end

  assign o_roll_cnt = roll_cnt;
`else
  logic unused_roll_set;
  assign unused_roll_set = roll_set;
`endif

endmodule
